// File: rtl/uart_rx_fifo.sv
// UART receiver: oversampled majority-vote bit recovery, configurable frame format,
// break detection and a show-ahead receive FIFO carrying per-byte error flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_serial,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_err_frame,
  output logic                        m_err_parity,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        overrun,
  output logic                        break_det,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  T_LO     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  T_MID    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  T_HI     = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]       DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [1:0]       SB_LAST  = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  logic [1:0]           r_sync;
  logic [1:0]           r_prime;
  logic                 r_armed;
  logic [DIV_W-1:0]     r_div_cnt;
  logic                 r_tick;
  state_t               r_state;
  logic [OS_W-1:0]      r_os_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_s0;
  logic                 r_s1;
  logic                 r_all_zero;
  logic                 r_err_par;
  logic                 r_err_frm;
  logic                 r_break;
  logic                 r_overrun;
  logic [ENT_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [ENT_W-1:0]     r_head;

  logic                 w_rx;
  logic                 w_res;
  logic                 w_bit;
  logic                 w_last_stop;
  logic                 w_is_break;
  logic                 w_push;
  logic [ENT_W-1:0]     w_push_data;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_wr;
  logic [PTR_W-1:0]     w_rd_next;

  assign w_rx = r_sync[1];

  // r_prime ensures arming is based on real line samples, not the reset value of the synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_prime <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx_serial};
      r_prime <= {r_prime[0], 1'b1};
      if (r_prime[1] && w_rx) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
      r_tick    <= 1'b0;
    end
  end

  assign w_res       = r_tick && (r_os_cnt == T_HI);
  assign w_bit       = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_last_stop = (r_state == S_STOP) && w_res && (r_bit_cnt[1:0] == SB_LAST);
  assign w_is_break  = r_all_zero && !w_bit;
  assign w_push      = w_last_stop && !w_is_break;
  assign w_push_data = {r_err_par, r_err_frm | ~w_bit, r_shift};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_all_zero <= 1'b1;
      r_err_par  <= 1'b0;
      r_err_frm  <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_break <= 1'b0;
      if (r_tick) begin
        r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
        if (r_os_cnt == T_LO)  r_s0 <= w_rx;
        if (r_os_cnt == T_MID) r_s1 <= w_rx;
      end
      case (r_state)
        S_IDLE: begin
          if (r_armed && !w_rx) begin
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_all_zero <= 1'b1;
            r_err_par  <= 1'b0;
            r_err_frm  <= 1'b0;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_res) r_state <= w_bit ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (w_res) begin
            r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_all_zero <= r_all_zero & ~w_bit;
            if (r_bit_cnt == DB_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (w_res) begin
            r_err_par  <= (PARITY == 2) ? ~(^r_shift ^ w_bit) : (^r_shift ^ w_bit);
            r_all_zero <= r_all_zero & ~w_bit;
            r_state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_res) begin
            r_err_frm  <= r_err_frm | ~w_bit;
            r_all_zero <= r_all_zero & ~w_bit;
            if (w_last_stop) begin
              r_state <= w_is_break ? S_BREAK : S_IDLE;
              r_break <= w_is_break;
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        S_BREAK: begin
          if (w_rx) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = (r_count != '0) && m_ready;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_rd_next = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_data;
  end

  // Head register is loaded from the next slot on pop, or bypassed from the push when that slot is being written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_head    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= w_rd_next;
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_pop);
      if (w_pop) begin
        if (r_count == CNT_W'(1)) begin
          if (w_wr) r_head <= w_push_data;
        end else begin
          r_head <= r_mem[w_rd_next];
        end
      end else if ((r_count == '0) && w_wr) begin
        r_head <= w_push_data;
      end
    end
  end

  assign m_data       = r_head[DATA_BITS-1:0];
  assign m_err_frame  = r_head[DATA_BITS];
  assign m_err_parity = r_head[DATA_BITS+1];
  assign m_valid      = (r_count != '0);
  assign fifo_count   = r_count;
  assign overrun      = r_overrun;
  assign break_det    = r_break;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance and an 8E2 instance, each driven by its own line,
// checked against per-instance queues of expected {err_parity, err_frame, data} entries.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int BAUD  = 115200;
  localparam int OS    = 16;
  localparam int DIVC  = 4;
  localparam int CLKF  = BAUD * OS * DIVC;
  localparam int BIT   = OS * DIVC;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      line, rdy, efr, epa, vld, ovr, brk;
  logic [1:0][7:0] dat;
  logic [1:0][4:0] cnt;

  int vectors = 0;
  int miscompares = 0;
  int exp_ovr[2], exp_brk[2], seen_ovr[2], seen_brk[2];
  logic [1:0] prev_ovr, prev_brk;
  logic [9:0] q0[$], q1[$], log0[$], log1[$];
  logic [9:0] cmp_act;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
    .clk(clk), .reset(reset), .rx_serial(line[0]), .m_data(dat[0]),
    .m_err_frame(efr[0]), .m_err_parity(epa[0]), .m_valid(vld[0]), .m_ready(rdy[0]),
    .overrun(ovr[0]), .break_det(brk[0]), .fifo_count(cnt[0]));

  uart_rx_fifo #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) dut1 (
    .clk(clk), .reset(reset), .rx_serial(line[1]), .m_data(dat[1]),
    .m_err_frame(efr[1]), .m_err_parity(epa[1]), .m_valid(vld[1]), .m_ready(rdy[1]),
    .overrun(ovr[1]), .break_det(brk[1]), .fifo_count(cnt[1]));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [9:0] qfront(input int k);
    if (k == 0) return q0[0];
    return q1[0];
  endfunction

  function automatic logic [9:0] logat(input int k, input int i);
    if (k == 0) return (i < log0.size()) ? log0[i] : 10'h3FF;
    return (i < log1.size()) ? log1[i] : 10'h3FF;
  endfunction

  function automatic int logsize(input int k);
    return (k == 0) ? log0.size() : log1.size();
  endfunction

  task automatic qpush(input int k, input logic [9:0] e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic qpop(input int k, input logic [9:0] act);
    if (k == 0) begin void'(q0.pop_front()); log0.push_back(act); end
    else begin void'(q1.pop_front()); log1.push_back(act); end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input int k, input logic v);
    line[k] = v;
    wait_clks(BIT);
  endtask

  // Expected entry follows the frame rules: even parity error = XOR(data, parity bit),
  // frame error = stop sampled 0, break = every sampled bit 0 (no entry).
  task automatic send_frame(input int k, input logic [7:0] d, input logic pbit, input logic stop_ok);
    logic epa_m, efr_m, is_brk;
    efr_m  = ~stop_ok;
    epa_m  = (k == 1) ? (^d ^ pbit) : 1'b0;
    is_brk = (d == 8'h00) && !stop_ok && ((k == 0) || !pbit);
    if (is_brk) exp_brk[k]++;
    else if (qsize(k) == DEPTH) exp_ovr[k]++;
    else qpush(k, {epa_m, efr_m, d});
    drive_bit(k, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(k, d[i]);
    if (k == 1) drive_bit(k, pbit);
    for (int i = 0; i < ((k == 1) ? 2 : 1); i++) drive_bit(k, stop_ok);
    if (!stop_ok) drive_bit(k, 1'b1);
    line[k] = 1'b1;
  endtask

  task automatic settle(input int k);
    chk("fifo_count_vs_model", k, cnt[k], qsize(k));
    chk("overrun_pulses", k, seen_ovr[k], exp_ovr[k]);
    chk("break_pulses", k, seen_brk[k], exp_brk[k]);
  endtask

  task automatic check_reset(input int k);
    chk("rst_m_data", k, dat[k], 0);
    chk("rst_err_frame", k, efr[k], 0);
    chk("rst_err_parity", k, epa[k], 0);
    chk("rst_m_valid", k, vld[k], 0);
    chk("rst_overrun", k, ovr[k], 0);
    chk("rst_break", k, brk[k], 0);
    chk("rst_fifo_count", k, cnt[k], 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_ovr = 2'b00;
      prev_brk = 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        cmp_act = {epa[k], efr[k], dat[k]};
        if (vld[k]) begin
          if (qsize(k) == 0) chk("head_with_empty_model", k, cmp_act, 10'h3FF);
          else chk("head", k, cmp_act, qfront(k));
          if (rdy[k] && qsize(k) != 0) qpop(k, cmp_act);
        end
        chk("valid_vs_count", k, vld[k], cnt[k] != 0);
        if (ovr[k]) begin
          seen_ovr[k]++;
          chk("overrun_width", k, prev_ovr[k], 0);
        end
        if (brk[k]) begin
          seen_brk[k]++;
          chk("break_width", k, prev_brk[k], 0);
        end
        prev_ovr[k] = ovr[k];
        prev_brk[k] = brk[k];
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_ovr = '{0, 0}; exp_brk = '{0, 0}; seen_ovr = '{0, 0}; seen_brk = '{0, 0};
    line = 2'b11; rdy = 2'b00; reset = 1'b1;
    wait_clks(5);
    check_reset(0);
    check_reset(1);
    reset = 1'b0;
    wait_clks(20);

    // 8N1 back to back
    rdy = 2'b11;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    wait_clks(BIT);
    settle(0);
    chk("8n1_first", 0, logat(0, 0), {2'b00, 8'hA5});
    chk("8n1_second", 0, logat(0, 1), {2'b00, 8'h3C});

    // even parity instance: 0x03 with parity 1 is a parity error, with parity 0 is clean
    send_frame(1, 8'h03, 1'b1, 1'b1);
    send_frame(1, 8'h03, 1'b0, 1'b1);
    wait_clks(BIT);
    settle(1);
    chk("parity_bad", 1, logat(1, 0), {2'b10, 8'h03});
    chk("parity_good", 1, logat(1, 1), {2'b00, 8'h03});

    // stop bit low then line high: framing error, no break
    send_frame(0, 8'h55, 1'b0, 1'b0);
    wait_clks(BIT);
    settle(0);
    chk("frame_err_entry", 0, logat(0, 2), {2'b01, 8'h55});
    chk("frame_err_no_break", 0, seen_brk[0], 0);

    // 20 bit times low: one break, then a clean byte
    exp_brk[0]++;
    line[0] = 1'b0;
    wait_clks(20 * BIT);
    line[0] = 1'b1;
    wait_clks(2 * BIT);
    settle(0);
    chk("break_once", 0, seen_brk[0], 1);
    chk("break_no_entry", 0, cnt[0], 0);
    send_frame(0, 8'h41, 1'b0, 1'b1);
    wait_clks(BIT);
    chk("after_break", 0, logat(0, 3), {2'b00, 8'h41});

    // overflow: 17 bytes with consumer stalled
    rdy[0] = 1'b0;
    for (int i = 0; i < 17; i++) send_frame(0, 8'(i), 1'b0, 1'b1);
    wait_clks(BIT);
    settle(0);
    chk("full_count", 0, cnt[0], 16);
    chk("one_overrun", 0, seen_ovr[0], 1);
    rdy[0] = 1'b1;
    wait_clks(40);
    settle(0);
    for (int i = 0; i < 16; i++) chk("drain_order", 0, logat(0, 4 + i), {2'b00, 8'(i)});

    // 2-tick glitch
    line[0] = 1'b0;
    wait_clks(2 * DIVC);
    line[0] = 1'b1;
    wait_clks(2 * BIT);
    settle(0);
    chk("glitch_no_entry", 0, logsize(0), 20);

    // randomized traffic on both instances in parallel
    for (int it = 0; it < 24; it++) begin
      logic [7:0] d0, d1;
      logic s0, s1, p1;
      d0 = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      d1 = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      s0 = ($urandom % 5 != 0);
      s1 = ($urandom % 5 != 0);
      p1 = (^d1) ^ ($urandom % 4 == 0);
      rdy[0] = (q0.size() >= 10) ? 1'b1 : 1'($urandom % 2);
      rdy[1] = (q1.size() >= 10) ? 1'b1 : 1'($urandom % 2);
      fork
        send_frame(0, d0, 1'b0, s0);
        send_frame(1, d1, p1, s1);
      join
    end
    rdy = 2'b11;
    wait_clks(BIT);
    settle(0);
    settle(1);

    // reset in the middle of data bit 4, line held low through release
    rdy[0] = 1'b0;
    send_frame(0, 8'h77, 1'b0, 1'b1);
    wait_clks(BIT);
    chk("pre_reset_count", 0, cnt[0], 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
    line[0] = 1'b0;
    wait_clks(BIT / 2);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    wait_clks(3);
    check_reset(0);
    check_reset(1);
    reset = 1'b0;
    wait_clks(3 * BIT);
    line[0] = 1'b1;
    wait_clks(2 * BIT);
    settle(0);
    chk("low_through_reset_no_entry", 0, vld[0], 0);
    rdy[0] = 1'b1;
    n = logsize(0);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    wait_clks(BIT);
    settle(0);
    chk("recovered_entry", 0, logat(0, n), {2'b00, 8'h5A});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with 16x oversampling, majority-vote bit sampling, configurable frame format and a show-ahead receive FIFO with valid/ready output. It replaces the fixed 8N1 receiver on the LiDAR serial link. It sits between the board `rx_serial` pin and the packet parser. Per-byte error sideband and break detection let the parser resynchronise on corrupted sensor frames.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock in Hz.
- `BAUD_RATE`, default 115200: line rate.
- `OVERSAMPLE`, default 16: ticks per bit; even, at least 8.
- `DATA_BITS`, default 8: legal range 5..9, sent LSB first.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 16: power of two, at least 2.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `rx_serial`  in  1: asynchronous line; idles high.
- `m_data`  out  DATA_BITS: FIFO head data.
- `m_err_frame`  out  1: head entry had a stop bit sampled 0.
- `m_err_parity`  out  1: head entry failed the parity check. Always 0 when PARITY=0.
- `m_valid`  out  1: FIFO not empty.
- `m_ready`  in  1: consumer pops the head when `m_valid && m_ready`.
- `overrun`  out  1: one-clk pulse when a completed frame is dropped because the FIFO is full.
- `break_det`  out  1: one-clk pulse on break detection.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Input synchroniser: 2 flops, reset to 1. All logic uses the synchronised `rx`.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division (54 at the defaults).
  - Free-running counter emits a 1-clk `tick` every DIV clocks.
- Bit sampling:
  - A per-bit tick counter runs 0..OVERSAMPLE-1.
  - `rx` is sampled at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the 2-of-3 majority, resolved at tick OVERSAMPLE/2+1.
- Arming: after reset the receiver ignores the line until synchronised `rx` has been seen high for at least one clk. A line held low through reset produces no frame.
- States:
  - IDLE: when armed and `rx`=0, clear the tick counter, go to START.
  - START: at majority resolution, value 1 means a glitch: return to IDLE with no output and no error. Value 0 goes to DATA.
  - DATA: DATA_BITS bits shifted in LSB first. Then go to PARITY if PARITY≠0, else STOP.
  - PARITY: one bit. Even mode errors when XOR(data, parity bit)=1; odd mode errors when it is 0.
  - STOP: STOP_BITS bits. `err_frame` is set if any stop bit samples 0.
    - After the last stop-bit resolution, go straight to IDLE without waiting out the bit, so back-to-back frames resync.
    - Same cycle, push {err_parity, err_frame, data} unless the frame is a break.
  - BREAK: entered from STOP when all data, parity and stop samples were 0. Pulse `break_det` and push nothing. Stay in BREAK until `rx`=1, then go to IDLE.
- FIFO:
  - Show-ahead: `m_data` and the error bits reflect the head whenever `m_valid`=1. They hold their previous value when empty.
  - Push while full with no pop in the same clk: drop the new frame and pulse `overrun`. Stored contents are unchanged.
  - Push and pop in the same clk while full: accept the push. Count stays at FIFO_DEPTH.
  - Push and pop in the same clk while empty: the push is stored. The pop is ignored because `m_valid`=0.
  - Pointers wrap modulo FIFO_DEPTH. `fifo_count` ranges 0..FIFO_DEPTH.
- Reset mid-frame: the frame is discarded, the FIFO emptied, and arming re-required.

## Timing
- Reset values:
  - `m_data`=0, `m_err_frame`=0, `m_err_parity`=0.
  - `m_valid`=0, `overrun`=0, `break_det`=0, `fifo_count`=0.
  - State IDLE, synchroniser all 1s.
- Line to state machine: 2 clk synchroniser delay.
- Latency: in the clk where the last stop bit resolves, the push is registered. `m_valid`, `m_data` and `fifo_count` update on the next clk edge (1 clk).
- Pop: `fifo_count` and head update 1 clk after a `m_valid && m_ready` edge.
- `overrun` and `break_det` pulses are 1 clk wide, on the clk after the stop-bit resolution.
- Start edge uncertainty: at most 1 tick. Sample point error stays within ±1/OVERSAMPLE bit.

## Test plan
- 8N1 at 115200, send 0xA5 then 0x3C back to back, `m_ready`=1 → two pops: 0xA5, then 0x3C. Both error bits 0, no `overrun`.
- PARITY=1, send 0x03 with parity bit 1 → entry 0x03 with `m_err_parity`=1, `m_err_frame`=0. With parity bit 0 → `m_err_parity`=0.
- Send 0x55 with stop bit driven 0 and line high afterwards → entry 0x55 with `m_err_frame`=1, no `break_det`.
- Hold line low for 20 bit times → exactly one `break_det` pulse and `fifo_count`=0. A following 0x41 is received cleanly.
- `m_ready`=0, FIFO_DEPTH=16, send 17 bytes 0x00..0x10:
  - `fifo_count`=16 and one `overrun` pulse on byte 0x10.
  - Draining yields 0x00..0x0F in order.
- Glitch and reset cases:
  - A low pulse of 2 ticks on an idle line → no entry, no error.
  - `reset` asserted at data bit 4 → all outputs return to reset values.
  - A line held low through reset release produces no entry.
